// File: rtl/t05_cb_sram_sched.sv
// t05_cb_sram_sched: round-robin owner of the single 32-bit SRAM word port.
// Requesters: ht (h-tree element fetch, 3 read beats), wr (codebook
// write-back, 4 write beats), tr (codebook read, 4 read beats).
// Wide transfers are split into little-word-first beats; read data is
// reassembled and published only when a burst completes.
// Optional feature macro: T05_SRAM_SCHED_TIMEOUT_EN (ack watchdog + sticky err).
`timescale 1ns/1ps

module t05_cb_sram_sched #(
    parameter logic [31:0] HTREE_BASE = 32'h0000_0000,
    parameter logic [31:0] CB_BASE    = 32'h0000_0600,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ht_req,
    input  logic [6:0]   ht_index,
    output logic [70:0]  ht_element,
    output logic         ht_done,
    input  logic         wr_req,
    input  logic [7:0]   wr_index,
    input  logic [127:0] wr_path,
    output logic         wr_done,
    input  logic         tr_req,
    input  logic [7:0]   tr_index,
    output logic [127:0] tr_path,
    output logic         tr_done,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic [2:0]   grant,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Select 32-bit word k of a 128-bit path.
    function automatic logic [31:0] word_sel(input logic [127:0] p, input logic [1:0] k);
        case (k)
            2'd0:    word_sel = p[31:0];
            2'd1:    word_sel = p[63:32];
            2'd2:    word_sel = p[95:64];
            2'd3:    word_sel = p[127:96];
            default: word_sel = p[31:0];
        endcase
    endfunction

    // Replace word k of a 128-bit path with w.
    function automatic logic [127:0] word_put(input logic [127:0] p, input logic [1:0] k,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = p;
        case (k)
            2'd0:    r[31:0]   = w;
            2'd1:    r[63:32]  = w;
            2'd2:    r[95:64]  = w;
            2'd3:    r[127:96] = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    // Ring arbiter: first requester at or after (last + 1) mod 3; bit0 ht, bit1 wr, bit2 tr.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
        logic [2:0] g;
        g = 3'b000;
        case (last)
            2'd0: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
                else           g = 3'b000;
            end
            2'd1: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
                else           g = 3'b000;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
                else           g = 3'b000;
            end
        endcase
        return g;
    endfunction

    // Ring position of a one-hot grant.
    function automatic logic [1:0] grant_idx(input logic [2:0] g);
        case (g)
            3'b010:  grant_idx = 2'd1;
            3'b100:  grant_idx = 2'd2;
            default: grant_idx = 2'd0;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     last_q, last_d;
    logic [2:0]     grant_q, grant_d;
    logic [1:0]     beat_q, beat_d;
    logic [127:0]   path_q, path_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           req_q, req_d;
    logic           busy_q, busy_d;
    logic [70:0]    ht_elem_q, ht_elem_d;
    logic [127:0]   tr_path_q, tr_path_d;
    logic           ht_done_q, ht_done_d;
    logic           wr_done_q, wr_done_d;
    logic           tr_done_q, tr_done_d;
    logic [2:0]     pick_s;
    logic [1:0]     last_beat_s;
    logic           finish_s;

`ifdef T05_SRAM_SCHED_TIMEOUT_EN
    localparam logic [31:0] TO_LAST_C = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    logic [31:0]    wait_cnt_q, wait_cnt_d;
    logic           err_q, err_d;
`else
    logic [31:0]    unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
`endif

    assign pick_s      = rr_pick(last_q, {tr_req, wr_req, ht_req});
    assign last_beat_s = grant_q[0] ? 2'd2 : 2'd3;

    // Next-state, burst sequencing and read reassembly.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        path_d    = path_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        req_d     = req_q;
        ht_elem_d = ht_elem_q;
        tr_path_d = tr_path_q;
        ht_done_d = 1'b0;
        wr_done_d = 1'b0;
        tr_done_d = 1'b0;
        finish_s  = 1'b0;
`ifdef T05_SRAM_SCHED_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_s != 3'b000) begin
                    state_d = ST_BURST;
                    grant_d = pick_s;
                    beat_d  = 2'd0;
                    req_d   = 1'b1;
`ifdef T05_SRAM_SCHED_TIMEOUT_EN
                    wait_cnt_d = 32'd0;
`endif
                    case (pick_s)
                        3'b001: begin
                            // 12*i = 8*i + 4*i
                            addr_d = HTREE_BASE + {22'd0, ht_index, 3'b000}
                                                + {23'd0, ht_index, 2'b00};
                            we_d   = 1'b0;
                            path_d = 128'd0;
                        end
                        3'b010: begin
                            addr_d  = CB_BASE + {20'd0, wr_index, 4'b0000};
                            we_d    = 1'b1;
                            path_d  = wr_path;
                            wdata_d = wr_path[31:0];
                        end
                        default: begin
                            addr_d = CB_BASE + {20'd0, tr_index, 4'b0000};
                            we_d   = 1'b0;
                            path_d = 128'd0;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (mem_ack) begin
`ifdef T05_SRAM_SCHED_TIMEOUT_EN
                    wait_cnt_d = 32'd0;
`endif
                    if (!we_q) begin
                        path_d = word_put(path_q, beat_q, mem_rdata);
                    end else begin
                        path_d = path_q;
                    end
                    if (beat_q == last_beat_s) begin
                        finish_s = 1'b1;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        addr_d  = addr_q + 32'd4;
                        wdata_d = word_sel(path_q, beat_q + 2'd1);
                    end
                end else begin
`ifdef T05_SRAM_SCHED_TIMEOUT_EN
                    if (wait_cnt_q >= TO_LAST_C) begin
                        finish_s = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 32'd1;
                    end
`else
                    state_d = ST_BURST;
`endif
                end
                if (finish_s) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    ht_done_d = grant_q[0];
                    wr_done_d = grant_q[1];
                    tr_done_d = grant_q[2];
                    if (grant_q[0]) begin
                        ht_elem_d = path_d[70:0];
                    end else begin
                        ht_elem_d = ht_elem_q;
                    end
                    if (grant_q[2]) begin
                        tr_path_d = path_d;
                    end else begin
                        tr_path_d = tr_path_q;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_DONE: begin
                last_d  = grant_idx(grant_q);
                grant_d = 3'b000;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'd2;
            grant_q   <= 3'b000;
            beat_q    <= 2'd0;
            path_q    <= 128'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            ht_elem_q <= 71'd0;
            tr_path_q <= 128'd0;
            ht_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            tr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            path_q    <= path_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            ht_elem_q <= ht_elem_d;
            tr_path_q <= tr_path_d;
            ht_done_q <= ht_done_d;
            wr_done_q <= wr_done_d;
            tr_done_q <= tr_done_d;
        end
    end

`ifdef T05_SRAM_SCHED_TIMEOUT_EN
    // Ack watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ht_element = ht_elem_q;
    assign ht_done    = ht_done_q;
    assign wr_done    = wr_done_q;
    assign tr_path    = tr_path_q;
    assign tr_done    = tr_done_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_t05_cb_sram_sched.sv
// Directed self-checking bench for t05_cb_sram_sched with a behavioural
// SRAM that acks after a programmable number of wait cycles.
`timescale 1ns/1ps

module tb_t05_cb_sram_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ht_req = 1'b0;
    logic [6:0]   ht_index = 7'd0;
    logic [70:0]  ht_element;
    logic         ht_done;
    logic         wr_req = 1'b0;
    logic [7:0]   wr_index = 8'd0;
    logic [127:0] wr_path = 128'd0;
    logic         wr_done;
    logic         tr_req = 1'b0;
    logic [7:0]   tr_index = 8'd0;
    logic [127:0] tr_path;
    logic         tr_done;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = 32'd0;
    logic         mem_ack = 1'b0;
    logic [2:0]   grant;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_err    = 0;

    // memory model controls and observation state
    int          ack_delay = 0;
    bit          ack_on    = 1'b1;
    int          wcnt      = 0;
    int          log_n     = 0;
    logic [31:0] log_addr [0:15];
    logic [31:0] log_data [0:15];
    logic        log_we   [0:15];
    int          stab_err = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;
    logic        prev_we = 1'b0;
    logic [2:0]  prev_grant = 3'b000;
    logic [2:0]  grant_log [0:7];
    int          gn = 0;
    int          ht_dc = 0;
    int          wr_dc = 0;
    int          tr_dc = 0;

    t05_cb_sram_sched #(
        .HTREE_BASE (32'h0000_0000),
        .CB_BASE    (32'h0000_0600),
        .TIMEOUT    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ht_req     (ht_req),
        .ht_index   (ht_index),
        .ht_element (ht_element),
        .ht_done    (ht_done),
        .wr_req     (wr_req),
        .wr_index   (wr_index),
        .wr_path    (wr_path),
        .wr_done    (wr_done),
        .tr_req     (tr_req),
        .tr_index   (tr_index),
        .tr_path    (tr_path),
        .tr_done    (tr_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .grant      (grant),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_003C: mem_read = 32'h1111_1111;
            32'h0000_0040: mem_read = 32'h2222_2222;
            32'h0000_0044: mem_read = 32'hFFFF_FF85;
            default:       mem_read = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the selected done pulse; cyc = posedges since the call.
    task automatic wait_done(input int which, input int max_cyc, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max_cyc) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            case (which)
                0:       got = ht_done;
                1:       got = wr_done;
                default: got = tr_done;
            endcase
        end
        if (!got) check_eq("done_timeout", 128'd0, 128'd1);
    endtask

    // SRAM model: ack after ack_delay wait cycles; also tracks grants, dones, stability.
    always @(negedge clk) begin
        if (mem_req && prev_wait &&
            (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
            stab_err++;
        if (mem_req && ack_on) begin
            if (wcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_read(mem_addr);
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        prev_wait  = mem_req && !mem_ack;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        if (ht_done) ht_dc++;
        if (wr_done) wr_dc++;
        if (tr_done) tr_dc++;
        if (grant != 3'b000 && prev_grant == 3'b000 && gn < 8) begin
            grant_log[gn] = grant;
            gn++;
        end
        prev_grant = grant;
    end

    // Log every accepted beat.
    always @(posedge clk) begin
        if (!rst && mem_req && mem_ack && log_n < 16) begin
            log_addr[log_n] = mem_addr;
            log_we[log_n]   = mem_we;
            log_data[log_n] = mem_we ? mem_wdata : mem_rdata;
            log_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int snap;
        repeat (2) @(negedge clk);
        // reset state
        check_eq("rst_grant", grant, 3'b000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_dones", {ht_done, wr_done, tr_done}, 3'b000);
        check_eq("rst_ht_element", ht_element, 71'd0);
        check_eq("rst_tr_path", tr_path, 128'd0);
        check_eq("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // zero-wait ht fetch
        log_n = 0;
        ht_index = 7'd5;
        ht_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ht_c1_req", {mem_req, mem_we, grant, busy}, {1'b1, 1'b0, 3'b001, 1'b1});
        check_eq("ht_c1_addr", mem_addr, 32'h3C);
        wait_done(0, 20, c);
        ht_req = 1'b0;
        check_eq("ht_latency", c + 1, 4);
        check_eq("ht_element", ht_element, {7'h05, 64'h2222_2222_1111_1111});
        check_eq("ht_beats", log_n, 3);
        for (int k = 0; k < 3; k++)
            check_eq("ht_addr", {log_we[k], log_addr[k]}, {1'b0, 32'h3C + 32'(4 * k)});
        @(negedge clk);
        check_eq("ht_done_pulse", {ht_done, busy, grant}, 5'b0);
        check_eq("tr_path_held", tr_path, 128'd0);

        // codebook write, operands changed after grant
        log_n = 0;
        wr_index = 8'd3;
        wr_path = 128'h1;
        wr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("wr_grant", grant, 3'b010);
        wr_path = {128{1'b1}};
        wr_index = 8'hFF;
        wait_done(1, 20, c);
        wr_req = 1'b0;
        check_eq("wr_latency", c + 1, 5);
        check_eq("wr_beats", log_n, 4);
        for (int k = 0; k < 4; k++) begin
            check_eq("wr_addr", {log_we[k], log_addr[k]}, {1'b1, 32'h630 + 32'(4 * k)});
            check_eq("wr_data", log_data[k], (k == 0) ? 32'd1 : 32'd0);
        end

        // tr read with 3 wait cycles per beat
        @(negedge clk);
        ack_delay = 3;
        stab_err = 0;
        log_n = 0;
        tr_index = 8'h10;
        tr_req = 1'b1;
        wait_done(2, 40, c);
        tr_req = 1'b0;
        check_eq("tr_latency", c, 17);
        check_eq("tr_path", tr_path, 128'hC0DE070C_C0DE0708_C0DE0704_C0DE0700);
        check_eq("tr_stable", stab_err, 0);
        check_eq("tr_beats", log_n, 4);
        check_eq("tr_addr3", log_addr[3], 32'h70C);
        check_eq("ht_element_held", ht_element, {7'h05, 64'h2222_2222_1111_1111});
        ack_delay = 0;

        // simultaneous requests from reset
        @(negedge clk);
        rst = 1'b1;
        ht_req = 1'b1;
        wr_req = 1'b1;
        tr_req = 1'b1;
        wr_index = 8'd3;
        @(negedge clk);
        rst = 1'b0;
        gn = 0;
        ht_dc = 0;
        wr_dc = 0;
        tr_dc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (ht_dc + wr_dc + tr_dc >= 4) break;
        end
        ht_req = 1'b0;
        wr_req = 1'b0;
        tr_req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_eq("rr_bursts", gn, 4);
        check_eq("rr_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
                 {3'b001, 3'b010, 3'b100, 3'b001});
        check_eq("rr_done_counts", {8'(ht_dc), 8'(wr_dc), 8'(tr_dc)}, {8'd2, 8'd1, 8'd1});

        // reset during beat 2 of a write
        ack_delay = 3;
        log_n = 0;
        wr_path = 128'hAAAA;
        wr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (log_n >= 2) break;
        end
        check_eq("rst_mid_beats", log_n, 2);
        snap = wr_dc;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_async", {mem_req, grant, busy}, 5'b0);
        wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        repeat (6) @(negedge clk);
        #1;
        check_eq("rst_mid_no_done", wr_dc, snap);
        log_n = 0;
        ht_req = 1'b1;
        wait_done(0, 20, c);
        ht_req = 1'b0;
        check_eq("post_rst_ht_latency", c, 4);
        check_eq("post_rst_ht_element", ht_element, {7'h05, 64'h2222_2222_1111_1111});
        check_eq("post_rst_ht_beats", log_n, 3);

`ifdef T05_SRAM_SCHED_TIMEOUT_EN
        // ack never returned: watchdog aborts the burst
        @(negedge clk);
        ack_on = 1'b0;
        tr_index = 8'd0;
        tr_req = 1'b1;
        wait_done(2, 30, c);
        tr_req = 1'b0;
        check_eq("to_latency", c, 5);
        check_eq("to_err", err, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("to_err_sticky", {err, mem_req}, 2'b10);
        ack_on = 1'b1;
`else
        check_eq("err_tied", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
